config_loader: RTL and testbench

- Write-side programming controller for the neuron configuration memories: the writer counterpart to the config memory read ports.
- Accepts a stream of AER-width configuration words over a valid/ready handshake and parses each packet into a header plus payload.
- Assembles the payload into the full memory-row width.
- Issues single-cycle write strobes (enable, address, data) to config memory A, B or C.
- Sits between the NoC local-port receive logic and the config memory write ports.

---
 rtl/config_loader_pkg.sv | 57 +++++
 rtl/config_loader_if.sv | 40 ++++
 rtl/config_loader_asm.sv | 35 +++
 rtl/config_loader.sv | 156 +++++++++++++++
 tb/tb_config_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/config_loader_pkg.sv
// Shared definitions for the config-memory write path: widths, header layout,
// select encodings and FSM states, so the config memories and the loader agree on row layout.
package config_loader_pkg;

  localparam int unsigned NUM_NURNS          = 256;
  localparam int unsigned NUM_AXONS          = 256;
  localparam int unsigned DSIZE              = 16;
  localparam int unsigned NURN_CNT_BIT_WIDTH = 8;
  localparam int unsigned AXON_CNT_BIT_WIDTH = 8;
  localparam int unsigned STDP_WIN_BIT_WIDTH = 8;
  localparam int unsigned AER_BIT_WIDTH      = 32;

  function automatic int unsigned mem_width_a();
    return 2 * STDP_WIN_BIT_WIDTH + 2 * DSIZE + 1;
  endfunction

  function automatic int unsigned mem_width_b();
    return 2 + 2 * DSIZE + AER_BIT_WIDTH;
  endfunction

  // Number of AER words needed to carry a row of the given width.
  function automatic int unsigned words_for(input int unsigned width);
    return (width + AER_BIT_WIDTH - 1) / AER_BIT_WIDTH;
  endfunction

  localparam int unsigned MEM_WIDTH_A = mem_width_a();
  localparam int unsigned MEM_WIDTH_B = mem_width_b();
  localparam int unsigned N_A         = words_for(MEM_WIDTH_A);
  localparam int unsigned N_B         = words_for(MEM_WIDTH_B);
  localparam int unsigned ADDR_W      = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
  localparam int unsigned CNT_W       = $clog2(N_B + 1);
  localparam int unsigned WRCNT_W     = 16;

  localparam int unsigned SEL_HI   = AER_BIT_WIDTH - 1;
  localparam int unsigned SEL_LO   = AER_BIT_WIDTH - 2;
  localparam int unsigned CBIT_POS = AER_BIT_WIDTH - 5;

  typedef enum logic [1:0] {
    SEL_A   = 2'b00,
    SEL_B   = 2'b01,
    SEL_C   = 2'b10,
    SEL_RSV = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PAYLOAD = 2'b01,
    ST_WRITE   = 2'b10
  } state_e;

  typedef struct packed {
    sel_e              sel;
    logic              cbit;
    logic [ADDR_W-1:0] addr;
  } hdr_t;

endpackage

// File: rtl/config_loader_if.sv
// Config word stream in, config memory A/B/C write strobes and status out.
interface config_loader_if;
  import config_loader_pkg::*;

  logic                          cfg_valid_i;
  logic [AER_BIT_WIDTH-1:0]      cfg_data_i;
  logic                          cfg_ready_o;
  logic                          wrEn_A_o;
  logic [NURN_CNT_BIT_WIDTH-1:0] wrAddr_A_o;
  logic [MEM_WIDTH_A-1:0]        wrData_A_o;
  logic                          wrEn_B_o;
  logic [NURN_CNT_BIT_WIDTH-1:0] wrAddr_B_o;
  logic [MEM_WIDTH_B-1:0]        wrData_B_o;
  logic                          wrEn_C_o;
  logic [ADDR_W-1:0]             wrAddr_C_o;
  logic                          wrData_C_o;
  logic                          busy_o;
  logic                          err_o;
  logic                          clr_err_i;
  logic [WRCNT_W-1:0]            wrCnt_o;

  modport master (
    input  cfg_valid_i, cfg_data_i, clr_err_i,
    output cfg_ready_o,
    output wrEn_A_o, wrAddr_A_o, wrData_A_o,
    output wrEn_B_o, wrAddr_B_o, wrData_B_o,
    output wrEn_C_o, wrAddr_C_o, wrData_C_o,
    output busy_o, err_o, wrCnt_o
  );

  modport slave (
    output cfg_valid_i, cfg_data_i, clr_err_i,
    input  cfg_ready_o,
    input  wrEn_A_o, wrAddr_A_o, wrData_A_o,
    input  wrEn_B_o, wrAddr_B_o, wrData_B_o,
    input  wrEn_C_o, wrAddr_C_o, wrData_C_o,
    input  busy_o, err_o, wrCnt_o
  );

endinterface

// File: rtl/config_loader_asm.sv
// Payload assembly: holds the earlier payload words and counts accepted words;
// row_c is the row as it would be with the current input word appended last.
module config_loader_asm
  import config_loader_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clr,
  input  logic                     shift,
  input  logic [AER_BIT_WIDTH-1:0] word,
  output logic [MEM_WIDTH_B-1:0]   row_c,
  output logic [CNT_W-1:0]         cnt
);

  localparam int unsigned HOLD_W = MEM_WIDTH_B - AER_BIT_WIDTH;

  logic [HOLD_W-1:0] hold;

  // Bits above the widest row fall off the top, so unused upper bits of word 0 vanish.
  assign row_c = {hold, word};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold <= '0;
      cnt  <= '0;
    end else if (clr) begin
      hold <= '0;
      cnt  <= '0;
    end else if (shift) begin
      hold <= row_c[HOLD_W-1:0];
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/config_loader.sv
// Parses header+payload packets from the config word stream and issues single-cycle
// write strobes to config memories A, B or C.
module config_loader
  import config_loader_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  config_loader_if.master bus
);

  state_e state, state_nx;
  hdr_t   hdr;

  logic                          ready_q, busy_q, err_q;
  logic                          accept;
  logic                          hdr_ab, hdr_c, hdr_rsv, pay_shift, pay_last;
  sel_e                          sel_q;
  logic [NURN_CNT_BIT_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]              cnt, last_idx;
  logic [MEM_WIDTH_B-1:0]        row_c;

  logic                          wr_en_a, wr_en_b, wr_en_c;
  logic [NURN_CNT_BIT_WIDTH-1:0] wr_addr_a, wr_addr_b;
  logic [MEM_WIDTH_A-1:0]        wr_data_a;
  logic [MEM_WIDTH_B-1:0]        wr_data_b;
  logic [ADDR_W-1:0]             wr_addr_c;
  logic                          wr_data_c;
  logic [WRCNT_W-1:0]            wr_cnt;

  assign hdr.sel  = sel_e'(bus.cfg_data_i[SEL_HI:SEL_LO]);
  assign hdr.cbit = bus.cfg_data_i[CBIT_POS];
  assign hdr.addr = bus.cfg_data_i[ADDR_W-1:0];

  assign accept   = bus.cfg_valid_i & ready_q;
  assign last_idx = (sel_q == SEL_A) ? CNT_W'(N_A - 1) : CNT_W'(N_B - 1);

  config_loader_asm u_asm (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr     (hdr_ab),
    .shift   (pay_shift),
    .word    (bus.cfg_data_i),
    .row_c   (row_c),
    .cnt     (cnt)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    hdr_ab    = 1'b0;
    hdr_c     = 1'b0;
    hdr_rsv   = 1'b0;
    pay_shift = 1'b0;
    pay_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (hdr.sel)
            SEL_A, SEL_B: begin
              hdr_ab   = 1'b1;
              state_nx = ST_PAYLOAD;
            end
            SEL_C: begin
              hdr_c    = 1'b1;
              state_nx = ST_WRITE;
            end
            default: hdr_rsv = 1'b1;
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          pay_shift = 1'b1;
          if (cnt == last_idx) begin
            pay_last = 1'b1;
            state_nx = ST_WRITE;
          end
        end
      end
      ST_WRITE: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Handshake/status registers track the state being entered so they line up with it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= SEL_A;
      addr_q  <= '0;
    end else begin
      ready_q <= (state_nx != ST_WRITE);
      busy_q  <= (state_nx != ST_IDLE);
      if (hdr_rsv)            err_q <= 1'b1;
      else if (bus.clr_err_i) err_q <= 1'b0;
      if (hdr_ab) begin
        sel_q  <= hdr.sel;
        addr_q <= hdr.addr[ADDR_W-1:AXON_CNT_BIT_WIDTH];
      end
    end
  end

  // Write ports: strobes pulse for one cycle, address/data hold until the next write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_en_a   <= 1'b0;
      wr_en_b   <= 1'b0;
      wr_en_c   <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      wr_data_a <= '0;
      wr_data_b <= '0;
      wr_addr_c <= '0;
      wr_data_c <= 1'b0;
      wr_cnt    <= '0;
    end else begin
      wr_en_a <= pay_last && (sel_q == SEL_A);
      wr_en_b <= pay_last && (sel_q == SEL_B);
      wr_en_c <= hdr_c;
      if (pay_last && (sel_q == SEL_A)) begin
        wr_addr_a <= addr_q;
        wr_data_a <= row_c[MEM_WIDTH_A-1:0];
      end
      if (pay_last && (sel_q == SEL_B)) begin
        wr_addr_b <= addr_q;
        wr_data_b <= row_c;
      end
      if (hdr_c) begin
        wr_addr_c <= hdr.addr;
        wr_data_c <= hdr.cbit;
      end
      if (pay_last || hdr_c) wr_cnt <= wr_cnt + WRCNT_W'(1);
    end
  end

  assign bus.cfg_ready_o = ready_q;
  assign bus.busy_o      = busy_q;
  assign bus.err_o       = err_q;
  assign bus.wrEn_A_o    = wr_en_a;
  assign bus.wrAddr_A_o  = wr_addr_a;
  assign bus.wrData_A_o  = wr_data_a;
  assign bus.wrEn_B_o    = wr_en_b;
  assign bus.wrAddr_B_o  = wr_addr_b;
  assign bus.wrData_B_o  = wr_data_b;
  assign bus.wrEn_C_o    = wr_en_c;
  assign bus.wrAddr_C_o  = wr_addr_c;
  assign bus.wrData_C_o  = wr_data_c;
  assign bus.wrCnt_o     = wr_cnt;

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: directed packets from the test plan plus
// randomized packets, checked against a word-concatenation reference model.
module tb_config_loader;
  import config_loader_pkg::*;

  typedef struct {
    int          mem;
    logic [15:0] addr;
    logic [65:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  config_loader_if bus ();

  config_loader dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.master)
  );

  exp_t        q[$];
  int          vectors    = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt    = 16'd0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    int   n;
    int   got_mem;
    exp_t e;
    if (rst_n && (bus.wrEn_A_o || bus.wrEn_B_o || bus.wrEn_C_o)) begin
      n = int'(bus.wrEn_A_o) + int'(bus.wrEn_B_o) + int'(bus.wrEn_C_o);
      got_mem = bus.wrEn_A_o ? 0 : (bus.wrEn_B_o ? 1 : 2);
      check("wren_onehot", 128'(n), 128'(1));
      check("ready_in_write", 128'(bus.cfg_ready_o), 128'(0));
      if (q.size() == 0) begin
        check("unexpected_write", 128'(q.size()), 128'(1));
      end else begin
        e = q.pop_front();
        exp_cnt = exp_cnt + 16'd1;
        check("wr_mem", 128'(got_mem), 128'(e.mem));
        case (got_mem)
          0: begin
            check("wr_addr_a", 128'(bus.wrAddr_A_o), 128'(e.addr));
            check("wr_data_a", 128'(bus.wrData_A_o), 128'(e.data));
          end
          1: begin
            check("wr_addr_b", 128'(bus.wrAddr_B_o), 128'(e.addr));
            check("wr_data_b", 128'(bus.wrData_B_o), 128'(e.data));
          end
          default: begin
            check("wr_addr_c", 128'(bus.wrAddr_C_o), 128'(e.addr));
            check("wr_data_c", 128'(bus.wrData_C_o), 128'(e.data));
          end
        endcase
        check("wr_cnt", 128'(bus.wrCnt_o), 128'(exp_cnt));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the word was accepted.
  task automatic send_word(input logic [31:0] w);
    int guard;
    guard = 0;
    bus.cfg_valid_i = 1'b1;
    bus.cfg_data_i  = w;
    @(negedge clk);
    while (!bus.cfg_ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("ready_timeout", 128'(bus.cfg_ready_o), 128'(1));
    @(posedge clk);
    #1;
    bus.cfg_valid_i = 1'b0;
  endtask

  task automatic idle_gap(input int n, input bit chk_busy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (chk_busy) check("busy_mid_packet", 128'(bus.busy_o), 128'(1));
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: payload words concatenated first-most-significant, low row bits kept.
  task automatic send_pkt(input logic [31:0] hdr, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input int gap_max);
    logic [1:0]  sel;
    logic [63:0] cat2;
    logic [95:0] cat3;
    exp_t        e;
    sel = hdr[31:30];
    send_word(hdr);
    if (sel == 2'b10) begin
      e.mem  = 2;
      e.addr = hdr[15:0];
      e.data = 66'(hdr[27]);
      q.push_back(e);
    end else if (sel == 2'b00) begin
      idle_gap($urandom_range(0, gap_max), 1'b1);
      send_word(w0);
      idle_gap($urandom_range(0, gap_max), 1'b1);
      send_word(w1);
      cat2   = {w0, w1};
      e.mem  = 0;
      e.addr = 16'(hdr[15:8]);
      e.data = 66'(cat2[48:0]);
      q.push_back(e);
    end else if (sel == 2'b01) begin
      idle_gap($urandom_range(0, gap_max), 1'b1);
      send_word(w0);
      idle_gap($urandom_range(0, gap_max), 1'b1);
      send_word(w1);
      idle_gap($urandom_range(0, gap_max), 1'b1);
      send_word(w2);
      cat3   = {w0, w1, w2};
      e.mem  = 1;
      e.addr = 16'(hdr[15:8]);
      e.data = cat3[65:0];
      q.push_back(e);
    end
  endtask

  task automatic check_reset_state();
    check("rst_ready", 128'(bus.cfg_ready_o), 128'(1));
    check("rst_busy", 128'(bus.busy_o), 128'(0));
    check("rst_err", 128'(bus.err_o), 128'(0));
    check("rst_wrcnt", 128'(bus.wrCnt_o), 128'(0));
    check("rst_wren", 128'({bus.wrEn_A_o, bus.wrEn_B_o, bus.wrEn_C_o}), 128'(0));
    check("rst_addr", 128'({bus.wrAddr_A_o, bus.wrAddr_B_o, bus.wrAddr_C_o}), 128'(0));
    check("rst_data", 128'({bus.wrData_A_o, bus.wrData_B_o, bus.wrData_C_o}), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h;
    bus.cfg_valid_i = 1'b0;
    bus.cfg_data_i  = '0;
    bus.clr_err_i   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_gap(2, 1'b0);

    // Directed A, B and C writes.
    send_pkt(32'h0000_0500, 32'h0001_ABCD, 32'h1234_5678, 32'h0, 0);
    send_pkt(32'h4000_FF00, 32'hFFFF_FFFF, 32'hAAAA_5555, 32'h0000_0001, 0);
    send_pkt(32'h8800_1234, 32'h0, 32'h0, 32'h0, 0);

    // Reserved select: error only, then recovery.
    send_word(32'hC000_0000);
    @(negedge clk);
    check("err_set", 128'(bus.err_o), 128'(1));
    @(posedge clk);
    #1;
    send_pkt(32'h8000_0001, 32'h0, 32'h0, 32'h0, 0);
    bus.clr_err_i = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err_i = 1'b0;
    @(negedge clk);
    check("err_clr", 128'(bus.err_o), 128'(0));
    @(posedge clk);
    #1;
    bus.clr_err_i = 1'b1;
    send_word(32'hC000_0000);
    bus.clr_err_i = 1'b0;
    @(negedge clk);
    check("err_set_wins", 128'(bus.err_o), 128'(1));
    @(posedge clk);
    #1;
    bus.clr_err_i = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err_i = 1'b0;

    // Gapped A packet: exactly three idle cycles between words.
    send_word(32'h0000_0500);
    idle_gap(3, 1'b1);
    send_word(32'h0001_ABCD);
    idle_gap(3, 1'b1);
    send_word(32'h1234_5678);
    q.push_back('{mem: 0, addr: 16'h0005, data: 66'h1_ABCD_1234_5678});

    // Reset mid-packet discards the partial B packet.
    idle_gap(2, 1'b0);
    send_word(32'h4000_0300);
    send_word(32'h1111_2222);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state();
    exp_cnt = 16'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_pkt(32'h0000_7700, 32'hFFFF_0F0F, 32'hCAFE_BABE, 32'h0, 1);

    // Randomized packets with random ignored header bits and gaps.
    for (int k = 0; k < 40; k++) begin
      h = $urandom;
      h[31:30] = 2'($urandom_range(0, 2));
      send_pkt(h, $urandom, $urandom, $urandom, 2);
    end

    idle_gap(4, 1'b0);
    check("drain", 128'(q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
